universal_shift_seq: RTL
========================

Name: universal_shift_seq

Overview:
- Parametrised, command-driven successor to the 4-bit universal shift register.
- Holds a WIDTH-bit register Q.
- Accepts one command at a time over a valid/ready handshake: parallel load, clear, hold, or a multi-step shift/rotate of CmdCount single-bit steps, executed one step per clock.
- Sits between datapath control and any block needing serialisation, barrel-free multi-bit shifts, or rotate.

Parameters:
- WIDTH, 8: register width in bits; minimum 2.
- CNT_W, $clog2(WIDTH)+1: width of the shift-count field; allows counts 0..2^CNT_W-1.

Ports:
- Clock  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-high reset.
- CmdValid  input  1  command present.
- CmdReady  output  1  block can accept a command.
- CmdMode  input  3  operation code (see Behaviour).
- CmdCount  input  CNT_W  number of single-bit steps for shift/rotate modes.
- L  input  WIDTH  parallel load data.
- SerInL  input  1  bit inserted at LSB on left shift.
- SerInR  input  1  bit inserted at MSB on logical right shift.
- Q  output  WIDTH  register contents; Q[WIDTH-1] is the MSB.
- CarryOut  output  1  last bit shifted or rotated out.
- Done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (synchronous, highest priority): Q=0, CarryOut=0, Done=0, state=IDLE, remaining=0. Asserting Reset mid-operation abandons the command; no Done pulse is issued for it.
- Mode codes:
  - 000 HOLD
  - 001 LOAD (Q<=L)
  - 010 SHL (Q<={Q[W-2:0],SerInL}, CarryOut<=Q[W-1])
  - 011 SHR (Q<={SerInR,Q[W-1:1]}, CarryOut<=Q[0])
  - 100 ASR (Q<={Q[W-1],Q[W-1:1]}, CarryOut<=Q[0])
  - 101 ROL (Q<={Q[W-2:0],Q[W-1]}, CarryOut<=Q[W-1])
  - 110 ROR (Q<={Q[0],Q[W-1:1]}, CarryOut<=Q[0])
  - 111 CLEAR (Q<=0, CarryOut<=0)
- CarryOut is unchanged by HOLD and LOAD.
- States: IDLE and SHIFT.
- CmdReady=1 only in IDLE. A command is accepted on an edge where CmdValid && CmdReady.
- IDLE, accept of HOLD/LOAD/CLEAR: the operation is applied at the accept edge, Done=1 for the following cycle, state stays IDLE. Back-to-back commands are allowed.
- IDLE, accept of a shift/rotate with CmdCount=0: Q and CarryOut unchanged, Done=1 next cycle, state stays IDLE.
- IDLE, accept of a shift/rotate with CmdCount=N≥1:
  - The first step is applied at the accept edge; remaining<=N-1 and the mode is latched.
  - If N=1: Done next cycle, stay IDLE.
  - Otherwise: go to SHIFT.
- SHIFT: one step per edge using the latched mode; remaining decrements each edge. The edge where remaining goes 1→0 is the last step: Done=1 next cycle, return to IDLE.
- Total latency: N edges from accept to final Q; Done is high in the cycle immediately after the Nth edge.
- Serial inputs are sampled live on each step edge, not latched at accept.
- Command fields (CmdMode, CmdCount, L) are ignored outside the accept edge.
- Done is a single-cycle pulse. In the cycle Done is high, CmdReady is high and a new command may be accepted.
- Counts larger than WIDTH are legal:
  - Rotates continue cycling.
  - SHL/SHR fill entirely with serial input.
  - ASR saturates to all copies of the sign bit.
- CmdValid while busy is simply not accepted; no error is raised.

Decomposition:
- Shared package universal_shift_pkg holds:
  - mode localparams (MODE_HOLD..MODE_CLEAR);
  - the state encoding (ST_IDLE, ST_SHIFT).
- Sub-module shift_step (combinational, WIDTH-parametrised):
  - inputs: Q, mode, SerInL, SerInR;
  - outputs: next Q, next CarryOut.
  - Used for both the accept-edge step and the SHIFT-state steps.
- The top level owns the FSM, the remaining counter, the latched mode, and Done.

Test Plan:
- Reset then LOAD L=8'hA5 → Q=8'hA5 one edge after accept, Done pulse next cycle, CmdReady stays 1.
- Q=8'h81, ROL count 3 → CmdReady low for 2 cycles; after 3 edges Q=8'h0C, CarryOut=0, single Done pulse.
- Q=8'h90, ASR count 2 → Q=8'hE4, CarryOut=0. Then SHR count 1 with SerInR=1 → Q=8'hF2, CarryOut=0.
- Q=8'h01, SHL count 9 with SerInL=0 → Q=8'h00, CarryOut=0 after 9 edges. SHL count 0 → Q unchanged, Done next cycle.
- Issue ROR count 4, assert Reset on the second SHIFT cycle → Q=0, Done never pulses, CmdReady=1 next cycle. Hold CmdValid high during a busy period → the second command is accepted only once back in IDLE.
- Two LOADs back to back (8'h11, 8'h22) in consecutive cycles → Q=8'h11 then 8'h22, Done high two consecutive cycles.

Source files
------------

// File: rtl/universal_shift_pkg.sv
// rtl/universal_shift_pkg.sv - mode codes, FSM state encoding and helpers for universal_shift_seq
package universal_shift_pkg;

  localparam logic [2:0] MODE_HOLD  = 3'b000;
  localparam logic [2:0] MODE_LOAD  = 3'b001;
  localparam logic [2:0] MODE_SHL   = 3'b010;
  localparam logic [2:0] MODE_SHR   = 3'b011;
  localparam logic [2:0] MODE_ASR   = 3'b100;
  localparam logic [2:0] MODE_ROL   = 3'b101;
  localparam logic [2:0] MODE_ROR   = 3'b110;
  localparam logic [2:0] MODE_CLEAR = 3'b111;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Multi-step modes: everything strictly between LOAD and CLEAR.
  function automatic logic is_shift_mode(input logic [2:0] mode);
    return (mode >= MODE_SHL) && (mode <= MODE_ROR);
  endfunction

endpackage

// File: rtl/shift_step.sv
// rtl/shift_step.sv - one combinational single-bit shift/rotate/clear step
module shift_step
  import universal_shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  logic [2:0]       mode,
  input  logic             ser_in_l,
  input  logic             ser_in_r,
  input  logic             carry_in,
  output logic [WIDTH-1:0] q_next,
  output logic             carry_next
);

  always_comb begin
    q_next     = q;
    carry_next = carry_in;
    case (mode)
      MODE_SHL: begin
        q_next     = {q[WIDTH-2:0], ser_in_l};
        carry_next = q[WIDTH-1];
      end
      MODE_SHR: begin
        q_next     = {ser_in_r, q[WIDTH-1:1]};
        carry_next = q[0];
      end
      MODE_ASR: begin
        q_next     = {q[WIDTH-1], q[WIDTH-1:1]};
        carry_next = q[0];
      end
      MODE_ROL: begin
        q_next     = {q[WIDTH-2:0], q[WIDTH-1]};
        carry_next = q[WIDTH-1];
      end
      MODE_ROR: begin
        q_next     = {q[0], q[WIDTH-1:1]};
        carry_next = q[0];
      end
      MODE_CLEAR: begin
        q_next     = '0;
        carry_next = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/universal_shift_seq.sv
// rtl/universal_shift_seq.sv - command-driven multi-step universal shift register
module universal_shift_seq
  import universal_shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             CmdValid,
  output logic             CmdReady,
  input  logic [2:0]       CmdMode,
  input  logic [CNT_W-1:0] CmdCount,
  input  logic [WIDTH-1:0] L,
  input  logic             SerInL,
  input  logic             SerInR,
  output logic [WIDTH-1:0] Q,
  output logic             CarryOut,
  output logic             Done
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic [2:0]         mode_q, mode_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic               carry_q, carry_d;
  logic               done_q, done_d;

  logic [2:0]         step_mode;
  logic [WIDTH-1:0]   step_q;
  logic               step_carry;

  // The accept edge steps with the incoming mode; SHIFT steps reuse the latched one.
  assign step_mode = (state_q == ST_SHIFT) ? mode_q : CmdMode;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .q          (q_q),
    .mode       (step_mode),
    .ser_in_l   (SerInL),
    .ser_in_r   (SerInR),
    .carry_in   (carry_q),
    .q_next     (step_q),
    .carry_next (step_carry)
  );

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    mode_d  = mode_q;
    q_d     = q_q;
    carry_d = carry_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (CmdValid) begin
          done_d = 1'b1;
          if (CmdMode == MODE_LOAD) begin
            q_d = L;
          end else if (is_shift_mode(CmdMode)) begin
            if (CmdCount != '0) begin
              q_d     = step_q;
              carry_d = step_carry;
              mode_d  = CmdMode;
              rem_d   = CmdCount - CNT_W'(1);
              if (CmdCount != CNT_W'(1)) begin
                done_d  = 1'b0;
                state_d = ST_SHIFT;
              end
            end
          end else begin
            q_d     = step_q;
            carry_d = step_carry;
          end
        end
      end
      ST_SHIFT: begin
        q_d     = step_q;
        carry_d = step_carry;
        rem_d   = rem_q - CNT_W'(1);
        if (rem_q == CNT_W'(1)) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      mode_q  <= MODE_HOLD;
      q_q     <= '0;
      carry_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      mode_q  <= mode_d;
      q_q     <= q_d;
      carry_q <= carry_d;
      done_q  <= done_d;
    end
  end

  assign CmdReady = (state_q == ST_IDLE);
  assign Q        = q_q;
  assign CarryOut = carry_q;
  assign Done     = done_q;

endmodule
